// File: rtl/rr_arbiter_param_pkg.sv
// Shared definitions for the parametrised round-robin arbiter: default
// sizing, FSM state encoding and the hold counter width helper.
package rr_arbiter_param_pkg;

   localparam int DEF_CHANNELS = 8;
   localparam int DEF_MAX_HOLD = 0;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // The hold counter only needs to reach MAX_HOLD-1, but it always keeps
   // at least one bit so the timeout-disabled build still elaborates.
   function automatic int hold_cnt_width(input int max_hold);
      return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
   endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational lowest-bit picker with priority mask and internal fallback.
// The masked request set wins when non-empty; otherwise the raw request set
// is used, which gives the round-robin wrap-around. Fixed mode ignores the
// mask entirely so the lowest requesting index always wins.
module rr_arb_pick
   import rr_arbiter_param_pkg::*;
#(
   parameter int W     = DEF_CHANNELS,
   parameter int IDX_W = $clog2(W)
) (
   input  logic [W-1:0]     req,
   input  logic [W-1:0]     mask,
   input  logic             fixed,
   output logic [W-1:0]     winner,
   output logic [IDX_W-1:0] idx,
   output logic             any_req
);

   logic [W-1:0] masked;
   logic [W-1:0] cand;

   // Choose the candidate set and isolate its lowest set bit
   always_comb begin
      masked  = req & mask;
      cand    = (fixed || (masked == '0)) ? req : masked;
      winner  = cand & (~cand + {{(W-1){1'b0}}, 1'b1});
      any_req = |req;
   end

   // Encode the one-hot winner into a binary index (0 when nothing wins)
   always_comb begin
      idx = '0;
      for (int i = 0; i < W; i++) begin
         if (winner[i]) idx = i[IDX_W-1:0];
      end
   end

endmodule

// File: rtl/rr_arbiter_param.sv
// Parametrised round-robin arbiter with a held, registered one-hot grant.
// The owner keeps the resource until it pulses done, drops its request, or
// (when MAX_HOLD > 0) exceeds its hold budget. Fixed-priority mode can be
// selected per pick without disturbing an active grant.
module rr_arbiter_param
   import rr_arbiter_param_pkg::*;
#(
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int MAX_HOLD = DEF_MAX_HOLD,
   parameter int IDX_W    = $clog2(CHANNELS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] request,
   input  logic                done,
   input  logic                fixed_prio,
   output logic [CHANNELS-1:0] grant,
   output logic                grant_valid,
   output logic [IDX_W-1:0]    grant_idx,
   output logic                timeout_evt
);

   localparam int HC_W = hold_cnt_width(MAX_HOLD);
   localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD - 1) : '0;

   arb_state_t          state;
   logic [CHANNELS-1:0] prio_mask;
   logic [HC_W-1:0]     hold_cnt;

   logic [CHANNELS-1:0] win;
   logic [IDX_W-1:0]    win_idx;
   logic                any_req;
   logic                owner_req;
   logic                timeout_hit;
   logic                release_evt;
   logic [CHANNELS-1:0] next_mask;

   rr_arb_pick #(
      .W     (CHANNELS),
      .IDX_W (IDX_W)
   ) u_pick (
      .req     (request),
      .mask    (prio_mask),
      .fixed   (fixed_prio),
      .winner  (win),
      .idx     (win_idx),
      .any_req (any_req)
   );

   // Release conditions for the current owner and the mask that a new grant
   // to the current winner would leave behind (only channels above it)
   always_comb begin
      owner_req   = |(request & grant);
      timeout_hit = (MAX_HOLD > 0) && (hold_cnt == HOLD_LAST);
      release_evt = done || !owner_req || timeout_hit;
      next_mask   = ~((win << 1) - {{(CHANNELS-1){1'b0}}, 1'b1});
   end

   // Arbitration FSM with registered grant, index, mask and hold counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         grant       <= '0;
         grant_valid <= 1'b0;
         grant_idx   <= '0;
         timeout_evt <= 1'b0;
         hold_cnt    <= '0;
         prio_mask   <= '1;
      end else begin
         timeout_evt <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant       <= win;
                  grant_valid <= 1'b1;
                  grant_idx   <= win_idx;
                  prio_mask   <= next_mask;
                  hold_cnt    <= '0;
                  state       <= GRANT;
               end
            end
            GRANT: begin
               if (release_evt) begin
                  timeout_evt <= timeout_hit && !done && owner_req;
                  if (any_req) begin
                     grant       <= win;
                     grant_valid <= 1'b1;
                     grant_idx   <= win_idx;
                     prio_mask   <= next_mask;
                     hold_cnt    <= '0;
                  end else begin
                     grant       <= '0;
                     grant_valid <= 1'b0;
                     grant_idx   <= '0;
                     state       <= IDLE;
                  end
               end else if (hold_cnt != {HC_W{1'b1}}) begin
                  hold_cnt <= hold_cnt + HC_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Directed testbench for rr_arbiter_param. Two instances share the inputs:
// one with the timeout disabled and one with MAX_HOLD=4.
module tb_rr_arbiter_param;

   logic       clk;
   logic       reset;
   logic [7:0] request;
   logic       done;
   logic       fixed_prio;

   logic [7:0] grant;
   logic       grant_valid;
   logic [2:0] grant_idx;
   logic       timeout_evt;

   logic [7:0] grant_t;
   logic       valid_t;
   logic [2:0] idx_t;
   logic       tevt_t;

   int total  = 0;
   int passed = 0;

   rr_arbiter_param #(.CHANNELS(8), .MAX_HOLD(0)) dut (
      .clk         (clk),
      .reset       (reset),
      .request     (request),
      .done        (done),
      .fixed_prio  (fixed_prio),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx),
      .timeout_evt (timeout_evt)
   );

   rr_arbiter_param #(.CHANNELS(8), .MAX_HOLD(4)) dut_to (
      .clk         (clk),
      .reset       (reset),
      .request     (request),
      .done        (done),
      .fixed_prio  (fixed_prio),
      .grant       (grant_t),
      .grant_valid (valid_t),
      .grant_idx   (idx_t),
      .timeout_evt (tevt_t)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop if the sequence ever stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired before summary");
      $fatal(1, "[TB] watchdog");
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      done  = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      request = 8'h00; done = 1'b0; fixed_prio = 1'b0; reset = 1'b1;
      step();
      total++; if (grant !== 8'h00) $display("[TB] FAIL rst_grant got %h want 00", grant); else passed++;
      total++; if (grant_valid !== 1'b0) $display("[TB] FAIL rst_valid got %b want 0", grant_valid); else passed++;
      total++; if (grant_idx !== 3'd0) $display("[TB] FAIL rst_idx got %0d want 0", grant_idx); else passed++;
      total++; if (timeout_evt !== 1'b0) $display("[TB] FAIL rst_tevt got %b want 0", timeout_evt); else passed++;
      reset = 1'b0;
      step();
      total++; if (grant !== 8'h00) $display("[TB] FAIL idle_noreq got %h want 00", grant); else passed++;
      request = 8'h05;
      step();
      total++; if (grant !== 8'h01) $display("[TB] FAIL first_grant got %h want 01", grant); else passed++;
      total++; if (grant_idx !== 3'd0) $display("[TB] FAIL first_idx got %0d want 0", grant_idx); else passed++;
      total++; if (grant_valid !== 1'b1) $display("[TB] FAIL first_valid got %b want 1", grant_valid); else passed++;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (grant !== 8'h01) $display("[TB] FAIL hold_%0d got %h want 01", i, grant); else passed++;
      end
   endtask

   task automatic test_back_to_back();
      done = 1'b1;
      step();
      done = 1'b0;
      total++; if (grant !== 8'h04) $display("[TB] FAIL b2b_next got %h want 04", grant); else passed++;
      total++; if (grant_idx !== 3'd2) $display("[TB] FAIL b2b_idx got %0d want 2", grant_idx); else passed++;
      done = 1'b1;
      step();
      done = 1'b0;
      total++; if (grant !== 8'h01) $display("[TB] FAIL b2b_wrap got %h want 01", grant); else passed++;
      total++; if (grant_idx !== 3'd0) $display("[TB] FAIL b2b_wrap_idx got %0d want 0", grant_idx); else passed++;
   endtask

   task automatic test_timeout();
      fixed_prio = 1'b0;
      request = 8'h81;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step();
         total++; if (grant_t !== 8'h01) $display("[TB] FAIL to_hold_%0d got %h want 01", i, grant_t); else passed++;
         total++; if (tevt_t !== 1'b0) $display("[TB] FAIL to_quiet_%0d got %b want 0", i, tevt_t); else passed++;
      end
      step();
      total++; if (grant_t !== 8'h80) $display("[TB] FAIL to_switch got %h want 80", grant_t); else passed++;
      total++; if (tevt_t !== 1'b1) $display("[TB] FAIL to_pulse got %b want 1", tevt_t); else passed++;
      step();
      total++; if (tevt_t !== 1'b0) $display("[TB] FAIL to_pulse_end got %b want 0", tevt_t); else passed++;
      total++; if (grant_t !== 8'h80) $display("[TB] FAIL to_newhold got %h want 80", grant_t); else passed++;
      step(); step(); step();
      total++; if (grant_t !== 8'h01) $display("[TB] FAIL to_wrap got %h want 01", grant_t); else passed++;
      total++; if (tevt_t !== 1'b1) $display("[TB] FAIL to_wrap_pulse got %b want 1", tevt_t); else passed++;
      step(); step(); step();
      done = 1'b1;
      step();
      done = 1'b0;
      total++; if (grant_t !== 8'h80) $display("[TB] FAIL to_done_grant got %h want 80", grant_t); else passed++;
      total++; if (tevt_t !== 1'b0) $display("[TB] FAIL to_done_prec got %b want 0", tevt_t); else passed++;
   endtask

   task automatic test_fixed_prio();
      fixed_prio = 1'b1;
      request = 8'h0A;
      do_reset();
      step();
      total++; if (grant !== 8'h02) $display("[TB] FAIL fp_first got %h want 02", grant); else passed++;
      total++; if (grant_idx !== 3'd1) $display("[TB] FAIL fp_idx got %0d want 1", grant_idx); else passed++;
      for (int i = 0; i < 2; i++) begin
         done = 1'b1;
         step();
         done = 1'b0;
         total++; if (grant !== 8'h02) $display("[TB] FAIL fp_regrant_%0d got %h want 02", i, grant); else passed++;
      end
      fixed_prio = 1'b0;
      step();
      total++; if (grant !== 8'h02) $display("[TB] FAIL fp_no_revoke got %h want 02", grant); else passed++;
      done = 1'b1;
      step();
      done = 1'b0;
      total++; if (grant !== 8'h08) $display("[TB] FAIL fp_to_rr got %h want 08", grant); else passed++;
      total++; if (grant_idx !== 3'd3) $display("[TB] FAIL fp_to_rr_idx got %0d want 3", grant_idx); else passed++;
   endtask

   task automatic test_implicit_release();
      fixed_prio = 1'b0;
      request = 8'h48;
      do_reset();
      step();
      total++; if (grant !== 8'h08) $display("[TB] FAIL ir_first got %h want 08", grant); else passed++;
      request = 8'h40;
      step();
      total++; if (grant !== 8'h40) $display("[TB] FAIL ir_drop got %h want 40", grant); else passed++;
      total++; if (grant_idx !== 3'd6) $display("[TB] FAIL ir_drop_idx got %0d want 6", grant_idx); else passed++;
      request = 8'h00;
      step();
      total++; if (grant !== 8'h00) $display("[TB] FAIL ir_idle got %h want 00", grant); else passed++;
      total++; if (grant_valid !== 1'b0) $display("[TB] FAIL ir_idle_valid got %b want 0", grant_valid); else passed++;
      step();
      total++; if (grant_idx !== 3'd0) $display("[TB] FAIL ir_idle_idx got %0d want 0", grant_idx); else passed++;
      request = 8'h02;
      step();
      total++; if (grant !== 8'h02) $display("[TB] FAIL ir_restart got %h want 02", grant); else passed++;
   endtask

   task automatic test_async_reset();
      fixed_prio = 1'b0;
      request = 8'hFF;
      do_reset();
      step();
      total++; if (grant !== 8'h01) $display("[TB] FAIL ar_first got %h want 01", grant); else passed++;
      done = 1'b1;
      step();
      done = 1'b0;
      total++; if (grant !== 8'h02) $display("[TB] FAIL ar_second got %h want 02", grant); else passed++;
      #2;
      reset = 1'b1;
      #1;
      total++; if (grant !== 8'h00) $display("[TB] FAIL ar_async_grant got %h want 00", grant); else passed++;
      total++; if (grant_valid !== 1'b0) $display("[TB] FAIL ar_async_valid got %b want 0", grant_valid); else passed++;
      total++; if (grant_idx !== 3'd0) $display("[TB] FAIL ar_async_idx got %0d want 0", grant_idx); else passed++;
      step();
      reset = 1'b0;
      step();
      total++; if (grant !== 8'h01) $display("[TB] FAIL ar_restart got %h want 01", grant); else passed++;
      total++; if (grant_idx !== 3'd0) $display("[TB] FAIL ar_restart_idx got %0d want 0", grant_idx); else passed++;
   endtask

   // Run every scenario in order, then report
   initial begin
      reset = 1'b1; request = 8'h00; done = 1'b0; fixed_prio = 1'b0;
      test_reset();
      test_back_to_back();
      test_timeout();
      test_fixed_prio();
      test_implicit_release();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
